// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer filter bank.
package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MIN_FILTER = 1;
  // Upper bound on vector width that popcount() can handle.
  localparam int unsigned SYNC_MAX_WIDTH  = 64;

  // Number of set bits in a vector zero-extended to SYNC_MAX_WIDTH.
  function automatic int unsigned popcount(input logic [SYNC_MAX_WIDTH-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < SYNC_MAX_WIDTH; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel of the bank: flop-chain synchronizer, persistence filter and
// registered rise/fall pulses derived from the filtered value.
module sync_filter_bit
  import sync_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_CNT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic filt_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FILTER_CNT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CNT - 1);

  logic [STAGES-1:0] chain_q, chain_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              filt_q, filt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  assign sync_out = chain_q[STAGES-1];
  assign filt_out = filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

  // Plain shift: no logic between synchronizer stages.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], din};
  end

  // Persistence filter: accept a new value only after FILTER_CNT consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_out != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync_out;
        cnt_d  = '0;
        rise_d = sync_out;
        fall_d = ~sync_out;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; everything clears on reset so propagation restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: rtl/sync_filter_bank.sv
// WIDTH independent synchronizer/filter channels. Optional gray-code checker
// enabled by defining SYNC_GRAY_CHECK_EN; without it gray_err is tied low.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_CNT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             gray_err
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_bank: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (FILTER_CNT < SYNC_MIN_FILTER) begin : g_bad_filter
    $error("sync_filter_bank: FILTER_CNT must be >= %0d", SYNC_MIN_FILTER);
  end
  if (WIDTH < 1 || WIDTH > SYNC_MAX_WIDTH) begin : g_bad_width
    $error("sync_filter_bank: WIDTH must be 1..%0d", SYNC_MAX_WIDTH);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sync_filter_bit #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din[g]),
      .sync_out (sync_out[g]),
      .filt_out (filt_out[g]),
      .rise     (rise[g]),
      .fall     (fall[g])
    );
  end

`ifdef SYNC_GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             gray_err_q, gray_err_d;

  assign gray_err = gray_err_q;

  // Sticky flag: a gray-coded vector may change at most one bit per cycle.
  always_comb begin
    prev_d     = sync_out;
    gray_err_d = gray_err_q;
    if (popcount(SYNC_MAX_WIDTH'(sync_out ^ prev_q)) > 1) begin
      gray_err_d = 1'b1;
    end
  end

  // Previous-value register and flag; only reset clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      gray_err_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      gray_err_q <= gray_err_d;
    end
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench for sync_filter_bank (WIDTH=4, STAGES=3, FILTER_CNT=4).
module tb_sync_filter_bank;

  localparam int W = 4;
  localparam int S = 3;
  localparam int F = 4;
`ifdef SYNC_GRAY_CHECK_EN
  localparam logic GRAY_EN = 1'b1;
`else
  localparam logic GRAY_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din   = '1;
  logic [W-1:0] sync_out, filt_out, rise, fall;
  logic         gray_err;

  int tests = 0;
  int fails = 0;

  sync_filter_bank #(
    .WIDTH      (W),
    .STAGES     (S),
    .FILTER_CNT (F)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .sync_out (sync_out),
    .filt_out (filt_out),
    .rise     (rise),
    .fall     (fall),
    .gray_err (gray_err)
  );

  always #5 clk = ~clk;

  // Reference model: din delayed S edges, filtered value flips once the last
  // F samples of the synced value all disagree with it.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_sync, m_filt, m_rise, m_fall, m_prev, m_cur;
  logic         m_err;
  bit           all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = {};
      m_hist = {};
      for (int i = 0; i < S; i++) m_q.push_back('0);
      for (int i = 0; i < F; i++) m_hist.push_back('0);
      m_sync = '0; m_filt = '0; m_rise = '0; m_fall = '0; m_prev = '0; m_err = 1'b0;
    end else begin
      m_cur = m_sync;
      if (GRAY_EN && $countones(m_cur ^ m_prev) > 1) m_err = 1'b1;
      m_prev = m_cur;
      m_hist.push_back(m_cur);
      void'(m_hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < F; j++) if (m_hist[j][i] == m_filt[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_filt[i] = ~m_filt[i];
          if (m_filt[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
        end
      end
      m_q.push_back(din);
      void'(m_q.pop_front());
      m_sync = m_q[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] s, input logic [W-1:0] f,
                         input logic [W-1:0] r, input logic [W-1:0] fl, input logic g);
    chk({tag, ".sync_out"}, 32'(sync_out), 32'(s));
    chk({tag, ".filt_out"}, 32'(filt_out), 32'(f));
    chk({tag, ".rise"}, 32'(rise), 32'(r));
    chk({tag, ".fall"}, 32'(fall), 32'(fl));
    chk({tag, ".gray_err"}, 32'(gray_err), 32'(g));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_sync, m_filt, m_rise, m_fall, m_err);
  endtask

  // One clock: returns at the following negedge, where outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered and left at a negedge; the next posedge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    din   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] din;
    int           n;
    logic [W-1:0] sync;
    logic [W-1:0] filt;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl[12];
  int   hold;

  initial begin
    // Rising edge, glitch on bit 1, then falling edge; each row holds din for
    // n cycles and expects the listed outputs after each of those cycles.
    tbl[0]  = '{4'h1, 2, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 4, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 1, 4'h1, 4'h1, 4'h1, 4'h0};
    tbl[3]  = '{4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[4]  = '{4'h3, 2, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[5]  = '{4'h1, 2, 4'h3, 4'h1, 4'h0, 4'h0};
    tbl[6]  = '{4'h1, 4, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[7]  = '{4'h0, 2, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[8]  = '{4'h0, 4, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[9]  = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[10] = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0};

    // Reset hold with all inputs high.
    @(negedge clk);
    for (int i = 0; i < 10; i++) step();
    chk_all("reset_hold", '0, '0, '0, '0, 1'b0);

    // Two-bit step on the synced vector.
    do_reset();
    step();
    din = 4'h3;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("gray_illegal", 32'(gray_err), 32'(GRAY_EN && e >= 4));
    end
    rst_n = 1'b0;
    #1;
    chk("gray_async_clear", 32'(gray_err), 32'(0));
    chk("gray_async_sync", 32'(sync_out), 32'(0));
    @(negedge clk);

    // Legal single-bit steps.
    do_reset();
    step();
    din = 4'h1;
    step();
    din = 4'h3;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("gray_legal", 32'(gray_err), 32'(0));
    end

    // Directed table from a clean reset.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      din = tbl[k].din;
      for (int c = 0; c < tbl[k].n; c++) begin
        step();
        chk_all($sformatf("tbl%0d_%0d", k, c), tbl[k].sync, tbl[k].filt, tbl[k].rise,
                tbl[k].fall, 1'b0);
      end
    end

    // Reset while the filter counter is part-way through.
    do_reset();
    din = 4'h1;
    for (int e = 0; e < 5; e++) step();
    chk("midrst_pre_sync", 32'(sync_out), 32'(1));
    chk("midrst_pre_filt", 32'(filt_out), 32'(0));
    rst_n = 1'b0;
    #1;
    chk_all("midrst_async", '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("midrst_rise", 32'(rise), 32'(e == 7 ? 1 : 0));
      chk("midrst_filt", 32'(filt_out), 32'(e >= 7 ? 1 : 0));
    end

    // Randomized run against the model, with occasional resets.
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        chk_model("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) din = din ^ (W'(1) << $urandom_range(0, W - 1));
        else din = W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      step();
      chk_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
